seq_det_event_monitor: RTL
==========================

// Module: seq_det_event_monitor
// PURPOSE
//   Downstream consumer of the serial sequence detector's det pulse. Counts detections, measures the gap
//   between consecutive hits, counts hits per fixed window, and raises an alarm when a window's count
//   reaches a threshold. The alarm is held until software or a controller acknowledges it.
// PARAMETERS
//   CNT_W   8   width of evt_cnt, win_cnt, last_gap and all internal counters (all saturating)
//   WIN_LEN 64  window length in enabled clock cycles; legal range 2..2^CNT_W
//   THRESH  4   window hit count at or above which alarm asserts; legal range 1..2^CNT_W-1
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   rst_n      in   1      synchronous active-low reset
//   en         in   1      1 = monitor runs; 0 = all counters and timers frozen, det_in ignored
//   det_in     in   1      detector output; every high cycle sampled with en=1 is one event
//   clr        in   1      synchronous clear of statistics and alarm
//   alarm_ack  in   1      one-cycle acknowledge of a pending alarm
//   evt_cnt    out  CNT_W  total events since reset or clr, saturating
//   win_cnt    out  CNT_W  event count of the last completed window
//   last_gap   out  CNT_W  cycles between the two most recent events, saturating
//   alarm      out  1      sticky threshold alarm
//   overflow   out  1      sticky; set when an event arrives while evt_cnt is all-ones
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): every output and internal register goes to 0, and the FSM goes to IDLE.
// - All outputs are registered. An effect is visible the cycle after the input that causes it is sampled.
// - FSM states: IDLE, RUN, ALARM.
//   - IDLE -> RUN when en=1.
//   - RUN -> ALARM when a window closes with a count >= THRESH.
//   - ALARM -> RUN on alarm_ack=1, unless a new threshold hit occurs in that same cycle.
//   - RUN or ALARM -> IDLE when en=0. The alarm flag is kept, and the block returns to ALARM on en=1 if the alarm is still set.
// - alarm = 1 exactly while the FSM is in ALARM, or in IDLE with the alarm flag set.
// - Event counting (en=1, clr=0, det_in=1):
//   - evt_cnt increments by 1, saturating at 2^CNT_W-1.
//   - If evt_cnt is already at 2^CNT_W-1, overflow is set to 1 instead and evt_cnt holds.
// - Gap measurement:
//   - gap_ctr counts enabled cycles since the last event and saturates at all-ones.
//   - On an event: last_gap <= gap_ctr + 1 (saturating), then gap_ctr <= 0.
//   - The first event after reset or clr only arms the measurement (seen_first=1). last_gap stays 0 on that event.
// - Window:
//   - win_timer counts 0..WIN_LEN-1 on enabled cycles. win_acc is a saturating per-window hit count.
//   - On the cycle where win_timer == WIN_LEN-1:
//     - win_cnt <= win_acc + det_in (saturating); this includes an event in the closing cycle.
//     - win_acc <= 0 and win_timer <= 0.
//     - If that new win_cnt >= THRESH, the alarm is set.
//   - Threshold evaluation happens only at window close, never mid-window.
// - en=0 mid-window: the timer pauses and resumes at the same count. Events during en=0 are lost, not queued.
// - Simultaneous events:
//   - clr beats det_in, window close and alarm_ack. The clr cycle zeroes evt_cnt, win_cnt, last_gap,
//     overflow, alarm, win_timer, win_acc, gap_ctr and seen_first. The FSM goes to RUN if en=1, else IDLE.
//   - A threshold hit in the same cycle as alarm_ack: the hit wins and alarm stays 1.
//   - alarm_ack while alarm=0 is ignored.
// - rst_n=0 mid-window or mid-alarm aborts everything; no partial window is reported.
// TESTING (bench overrides: CNT_W=4, WIN_LEN=8, THRESH=2)
// 1. Reset, en=1, det_in high on cycles 2 and 5, then low
//    -> evt_cnt=1 then 2; last_gap=0 after the first event, =3 after the second;
//       at window close (cycle 7): win_cnt=2, alarm=1 the next cycle.
// 2. alarm=1; pulse alarm_ack; next window has 1 event
//    -> alarm drops the cycle after ack; win_cnt=1; alarm stays 0.
// 3. Events on cycles 6 and 7 of a window (cycle 7 = close), with alarm_ack also on cycle 7
//    -> win_cnt=2; alarm remains 1 (hit beats ack).
// 4. 17 events with no clr
//    -> evt_cnt saturates at 15 after the 15th; overflow=1 after the 16th; evt_cnt holds at 15.
// 5. en=0 for 5 cycles mid-window (timer=3) with det_in toggling
//    -> counters unchanged; the window closes 4 enabled cycles after en returns.
// 6. clr asserted together with det_in=1 and window close
//    -> all outputs 0 the next cycle; evt_cnt stays 0 (the event is dropped).

Source files
------------

// File: rtl/seq_det_event_monitor.sv
// -----------------------------------------------------------------------------
// seq_det_event_monitor
//
// Consumes the single-cycle detection pulse of a serial sequence detector and
// keeps running statistics on it:
//   * total event count (saturating, with a sticky overflow flag)
//   * gap, in enabled cycles, between the two most recent events
//   * hit count of the last completed fixed-length window
//   * sticky threshold alarm raised at window close, held until acknowledged
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   en         in   1      1 = monitor runs; 0 = everything frozen, det_in ignored
//   det_in     in   1      detector output; each high cycle with en=1 is one event
//   clr        in   1      synchronous clear of statistics and alarm
//   alarm_ack  in   1      one-cycle acknowledge of a pending alarm
//   evt_cnt    out  CNT_W  events since reset/clr, saturating
//   win_cnt    out  CNT_W  event count of the last completed window
//   last_gap   out  CNT_W  cycles between the two most recent events, saturating
//   alarm      out  1      sticky threshold alarm
//   overflow   out  1      sticky; event arrived while evt_cnt was all-ones
//
// Parameters
//   CNT_W    width of every counter (2..)
//   WIN_LEN  window length in enabled cycles, 2..2^CNT_W
//   THRESH   window count at or above which the alarm is raised, 1..2^CNT_W-1
// -----------------------------------------------------------------------------
module seq_det_event_monitor #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 64,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             det_in,
    input  logic             clr,
    input  logic             alarm_ack,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] last_gap,
    output logic             alarm,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Timer value of the closing cycle; WIN_LEN <= 2^CNT_W keeps this in range.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t           state_r;
    logic             alarm_flag_r;
    logic [CNT_W-1:0] gap_ctr_r;
    logic [CNT_W-1:0] win_timer_r;
    logic [CNT_W-1:0] win_acc_r;
    logic             seen_first_r;

    logic [CNT_W-1:0] evt_cnt_s;
    logic             overflow_s;
    logic [CNT_W-1:0] last_gap_s;
    logic [CNT_W-1:0] gap_ctr_s;
    logic             seen_first_s;
    logic [CNT_W-1:0] win_total_s;
    logic [CNT_W-1:0] win_timer_s;
    logic [CNT_W-1:0] win_acc_s;
    logic [CNT_W-1:0] win_cnt_s;
    logic             hit_s;

    // Next-state datapath for the enabled, non-clear case; holds when en=0.
    always_comb begin
        evt_cnt_s    = evt_cnt;
        overflow_s   = overflow;
        last_gap_s   = last_gap;
        gap_ctr_s    = gap_ctr_r;
        seen_first_s = seen_first_r;
        win_timer_s  = win_timer_r;
        win_acc_s    = win_acc_r;
        win_cnt_s    = win_cnt;
        hit_s        = 1'b0;
        // Window total including an event in the current cycle.
        win_total_s  = det_in ? sat_inc(win_acc_r) : win_acc_r;

        if (en) begin
            if (det_in) begin
                if (evt_cnt == CNT_MAX) begin
                    overflow_s = 1'b1;
                end else begin
                    evt_cnt_s = evt_cnt + CNT_ONE;
                end
                // The first event only arms the gap measurement.
                if (seen_first_r) begin
                    last_gap_s = sat_inc(gap_ctr_r);
                end else begin
                    last_gap_s = last_gap;
                end
                seen_first_s = 1'b1;
                gap_ctr_s    = CNT_ZERO;
            end else begin
                gap_ctr_s = sat_inc(gap_ctr_r);
            end

            if (win_timer_r == WIN_LAST) begin
                win_cnt_s   = win_total_s;
                win_acc_s   = CNT_ZERO;
                win_timer_s = CNT_ZERO;
                hit_s       = (win_total_s >= THRESH_V);
            end else begin
                win_acc_s   = win_total_s;
                win_timer_s = win_timer_r + CNT_ONE;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Statistics registers; clr has priority over every enabled update.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            evt_cnt      <= CNT_ZERO;
            overflow     <= 1'b0;
            last_gap     <= CNT_ZERO;
            gap_ctr_r    <= CNT_ZERO;
            seen_first_r <= 1'b0;
            win_timer_r  <= CNT_ZERO;
            win_acc_r    <= CNT_ZERO;
            win_cnt      <= CNT_ZERO;
        end else begin
            evt_cnt      <= evt_cnt_s;
            overflow     <= overflow_s;
            last_gap     <= last_gap_s;
            gap_ctr_r    <= gap_ctr_s;
            seen_first_r <= seen_first_s;
            win_timer_r  <= win_timer_s;
            win_acc_r    <= win_acc_s;
            win_cnt      <= win_cnt_s;
        end
    end

    // Alarm FSM with registered alarm output; a window hit beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            alarm_flag_r <= 1'b0;
            alarm        <= 1'b0;
        end else if (clr) begin
            state_r      <= en ? RUN : IDLE;
            alarm_flag_r <= 1'b0;
            alarm        <= 1'b0;
        end else if (!en) begin
            // Paused: flag is retained and still visible on the alarm output.
            state_r <= IDLE;
            alarm   <= alarm_flag_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s || (alarm_flag_r && !alarm_ack)) begin
                        state_r      <= ALARM;
                        alarm_flag_r <= 1'b1;
                        alarm        <= 1'b1;
                    end else begin
                        state_r      <= RUN;
                        alarm_flag_r <= 1'b0;
                        alarm        <= 1'b0;
                    end
                end
                RUN: begin
                    if (hit_s) begin
                        state_r      <= ALARM;
                        alarm_flag_r <= 1'b1;
                        alarm        <= 1'b1;
                    end else begin
                        state_r      <= RUN;
                        alarm_flag_r <= 1'b0;
                        alarm        <= 1'b0;
                    end
                end
                ALARM: begin
                    if (alarm_ack && !hit_s) begin
                        state_r      <= RUN;
                        alarm_flag_r <= 1'b0;
                        alarm        <= 1'b0;
                    end else begin
                        state_r      <= ALARM;
                        alarm_flag_r <= 1'b1;
                        alarm        <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    alarm_flag_r <= 1'b0;
                    alarm        <= 1'b0;
                end
            endcase
        end
    end

endmodule
